// File: rtl/fifo_replay_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_replay_pkg
// Purpose  : Shared types and width helpers for the replay FIFO.
//            fillStatus is the registered flag bundle presented on the bus;
//            fifoOutputEnableFlags names the bit position of each flag
//            inside that bundle.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_replay_pkg;

    // MSB first: {empty, almostEmpty, full, almostFull, valid}
    typedef struct packed {
        logic empty;
        logic almostEmpty;
        logic full;
        logic almostFull;
        logic valid;
    } fillStatus;

    typedef enum logic [2:0] {
        FLAG_VALID        = 3'd0,
        FLAG_ALMOST_FULL  = 3'd1,
        FLAG_FULL         = 3'd2,
        FLAG_ALMOST_EMPTY = 3'd3,
        FLAG_EMPTY        = 3'd4
    } fifoOutputEnableFlags;

    // Pointer width: indexes 0..DEPTH-1, never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Count width: holds 0..DEPTH inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_replay_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_replay_if
// Purpose  : Producer/consumer bus of the replay FIFO.
//            master : the side driving writes, pops, commit and rewind
//            slave  : the FIFO itself
// Signals  : wr_valid/wr_ready/wr_data   write handshake
//            rd_valid/rd_ready/rd_data   read handshake (FWFT head word)
//            commit, rewind              replay control
//            status, fill_level, rd_avail, overflow   occupancy reporting
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_replay_if
    import fifo_replay_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 24
) ();
    localparam int CW = cnt_width(DEPTH);

    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;
    logic             commit;
    logic             rewind;
    fillStatus        status;
    logic [CW-1:0]    fill_level;
    logic [CW-1:0]    rd_avail;
    logic             overflow;

    modport master (
        output wr_valid, wr_data, rd_ready, commit, rewind,
        input  wr_ready, rd_valid, rd_data, status, fill_level, rd_avail, overflow
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready, commit, rewind,
        output wr_ready, rd_valid, rd_data, status, fill_level, rd_avail, overflow
    );

endinterface
`default_nettype wire

// File: rtl/fifo_replay_wrap_ptr.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wrap_ptr
// Purpose  : Ring pointer over 0..DEPTH-1 with explicit DEPTH-1 -> 0 wrap,
//            so DEPTH need not be a power of two. Load beats increment.
// Ports    : clk, rst        clock, synchronous active-high reset
//            i_inc           advance by one (with wrap)
//            i_load          replace with i_load_val
//            i_load_val      load value
//            o_ptr           registered pointer
//            o_ptr_next      value o_ptr takes at the next edge
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wrap_ptr
    import fifo_replay_pkg::*;
#(
    parameter  int DEPTH = 24,
    localparam int PW    = ptr_width(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_inc,
    input  wire logic          i_load,
    input  wire logic [PW-1:0] i_load_val,
    output logic      [PW-1:0] o_ptr,
    output logic      [PW-1:0] o_ptr_next
);
    localparam logic [PW-1:0] c_last = PW'(DEPTH - 1);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_next;

    always_comb begin
        w_next = r_ptr;
        if (i_load) begin
            w_next = i_load_val;
        end else if (i_inc) begin
            w_next = (r_ptr == c_last) ? '0 : r_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_next;
        end
    end

    assign o_ptr      = r_ptr;
    assign o_ptr_next = w_next;

endmodule
`default_nettype wire

// File: rtl/fifo_replay.sv
`default_nettype none
// ============================================================================
// Module   : fifo_replay
// Purpose  : Synchronous FWFT FIFO of arbitrary DEPTH with transactional
//            replay. Popped words stay owned by the FIFO until commit;
//            rewind moves the read pointer back to the oldest uncommitted
//            word. With REPLAY=0 every pop commits implicitly.
// Ports    : clk    clock
//            reset  synchronous active-high reset
//            bus    fifo_replay_if.slave (handshakes, replay control, status)
// Revision : 1.0 - initial release
// ============================================================================
module fifo_replay
    import fifo_replay_pkg::*;
#(
    parameter int WIDTH              = 32,
    parameter int DEPTH              = 24,
    parameter int REPLAY             = 1,
    parameter int TRIGGERALMOSTFULL  = 2,
    parameter int TRIGGERALMOSTEMPTY = 2
) (
    input wire logic     clk,
    input wire logic     reset,
    fifo_replay_if.slave bus
);
    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    localparam logic [CW-1:0] c_depth_cnt = CW'(DEPTH);
    localparam bit            c_replay    = (REPLAY != 0);
    localparam int            c_af_thresh = DEPTH - TRIGGERALMOSTFULL;

    localparam fillStatus c_status_rst = '{
        empty:       1'b1,
        almostEmpty: 1'b1,
        full:        1'b0,
        almostFull:  (DEPTH <= TRIGGERALMOSTFULL),
        valid:       1'b0
    };

    // ---------------------------------------------------------------- state
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_fill;
    logic [CW-1:0]    r_rd_avail;
    logic             r_wr_ready;
    logic             r_rd_valid;
    logic [WIDTH-1:0] r_rd_data;
    fillStatus        r_status;
    logic             r_overflow;

    // ---------------------------------------------------------------- control
    logic          w_push;
    logic          w_pop;
    logic          w_commit;
    logic          w_rewind;
    logic [PW-1:0] w_wr_ptr,     w_wr_ptr_next;
    logic [PW-1:0] w_rd_ptr,     w_rd_ptr_next;
    logic [PW-1:0] w_commit_ptr, w_commit_ptr_next;
    logic [CW-1:0] w_rd_avail_next;
    logic [CW-1:0] w_fill_next;
    fillStatus     w_status_next;
    logic [WIDTH-1:0] w_rd_word;

    assign w_push   = bus.wr_valid && r_wr_ready;
    assign w_commit = c_replay && bus.commit;
    // Commit takes priority when both are requested.
    assign w_rewind = c_replay && bus.rewind && !bus.commit;
    // A pop handshake in a rewind cycle is dropped.
    assign w_pop    = r_rd_valid && bus.rd_ready && !w_rewind;

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk        (clk),
        .rst        (reset),
        .i_inc      (w_push),
        .i_load     (1'b0),
        .i_load_val ('0),
        .o_ptr      (w_wr_ptr),
        .o_ptr_next (w_wr_ptr_next)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk        (clk),
        .rst        (reset),
        .i_inc      (w_pop),
        .i_load     (w_rewind),
        .i_load_val (w_commit_ptr),
        .o_ptr      (w_rd_ptr),
        .o_ptr_next (w_rd_ptr_next)
    );

    // Without replay the commit pointer simply shadows the read pointer.
    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_commit_ptr (
        .clk        (clk),
        .rst        (reset),
        .i_inc      (1'b0),
        .i_load     (!c_replay || w_commit),
        .i_load_val (w_rd_ptr_next),
        .o_ptr      (w_commit_ptr),
        .o_ptr_next (w_commit_ptr_next)
    );

    logic w_unused;
    assign w_unused = ^{w_wr_ptr_next, w_commit_ptr_next, w_rd_ptr};

    always_comb begin
        w_rd_avail_next = r_rd_avail + CW'(w_push) - CW'(w_pop);
        if (w_rewind) begin
            w_rd_avail_next = r_fill + CW'(w_push);
        end

        w_fill_next = r_fill + CW'(w_push);
        if (!c_replay || w_commit) begin
            w_fill_next = w_rd_avail_next;
        end

        w_status_next.empty       = (w_rd_avail_next == '0);
        w_status_next.almostEmpty = (int'(w_rd_avail_next) <= TRIGGERALMOSTEMPTY);
        w_status_next.full        = (w_fill_next == c_depth_cnt);
        w_status_next.almostFull  = (int'(w_fill_next) >= c_af_thresh);
        w_status_next.valid       = (w_rd_avail_next != '0);

        // Fall-through: if the next head slot is the one being written now,
        // take the word straight from the write port.
        w_rd_word = r_mem[w_rd_ptr_next];
        if (w_push && (w_rd_ptr_next == w_wr_ptr)) begin
            w_rd_word = bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fill     <= '0;
            r_rd_avail <= '0;
            r_wr_ready <= 1'b1;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_status   <= c_status_rst;
            r_overflow <= 1'b0;
        end else begin
            r_fill     <= w_fill_next;
            r_rd_avail <= w_rd_avail_next;
            r_wr_ready <= (w_fill_next != c_depth_cnt);
            r_rd_valid <= (w_rd_avail_next != '0);
            r_rd_data  <= w_rd_word;
            r_status   <= w_status_next;
            if (bus.wr_valid && !r_wr_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.wr_ready   = r_wr_ready;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.rd_data    = r_rd_data;
    assign bus.status     = r_status;
    assign bus.fill_level = r_fill;
    assign bus.rd_avail   = r_rd_avail;
    assign bus.overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_replay.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_replay
// Purpose  : Directed self-checking bench for fifo_replay at DEPTH=5,
//            REPLAY=1, both triggers 2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_replay;
    import fifo_replay_pkg::*;

    localparam int W = 32;
    localparam int D = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_replay_if #(.WIDTH(W), .DEPTH(D)) bus ();

    fifo_replay #(
        .WIDTH              (W),
        .DEPTH              (D),
        .REPLAY             (1),
        .TRIGGERALMOSTFULL  (2),
        .TRIGGERALMOSTEMPTY (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        bus.commit   = 1'b0;
        bus.rewind   = 1'b0;
    endtask

    task automatic push_w(input logic [W-1:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [W-1:0] exp, input logic cm);
        check_eq({tag, ".valid"}, 64'(bus.rd_valid), 64'd1);
        check_eq({tag, ".data"},  64'(bus.rd_data),  64'(exp));
        bus.rd_ready = 1'b1;
        bus.commit   = cm;
        tick();
        bus.rd_ready = 1'b0;
        bus.commit   = 1'b0;
    endtask

    task automatic check_cnt(input string tag, input int fill, input int avail);
        check_eq({tag, ".fill"},  64'(bus.fill_level), 64'(fill));
        check_eq({tag, ".avail"}, 64'(bus.rd_avail),   64'(avail));
    endtask

    // {empty, almostEmpty, full, almostFull, valid} after each of 5 pushes
    logic [4:0] st_fill [5] = '{5'b01001, 5'b01001, 5'b00011, 5'b00011, 5'b00111};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // ---------------- reset state
        check_eq("rst.wr_ready", 64'(bus.wr_ready), 64'd1);
        check_eq("rst.rd_valid", 64'(bus.rd_valid), 64'd0);
        check_eq("rst.rd_data",  64'(bus.rd_data),  64'd0);
        check_eq("rst.status",   64'(bus.status),   64'b11000);
        check_eq("rst.overflow", 64'(bus.overflow), 64'd0);
        check_cnt("rst", 0, 0);

        // ---------------- fill to full, then overflow
        for (int i = 0; i < D; i++) begin
            push_w(32'hA0 + 32'(i));
            check_eq($sformatf("full.st%0d", i), 64'(bus.status), 64'(st_fill[i]));
            check_eq($sformatf("full.wrdy%0d", i), 64'(bus.wr_ready), (i < D - 1) ? 64'd1 : 64'd0);
            check_cnt($sformatf("full.c%0d", i), i + 1, i + 1);
        end
        check_eq("full.head", 64'(bus.rd_data), 64'hA0);

        push_w(32'hEE);
        check_eq("ovf.flag", 64'(bus.overflow), 64'd1);
        check_cnt("ovf", 5, 5);

        // pop+commit while full: the concurrent push is still refused
        check_eq("drain0.data", 64'(bus.rd_data), 64'hA0);
        bus.rd_ready = 1'b1;
        bus.commit   = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'hEF;
        tick();
        idle();
        check_cnt("drain0", 4, 4);
        check_eq("drain0.wrdy", 64'(bus.wr_ready), 64'd1);
        for (int i = 1; i < D; i++) begin
            pop_chk($sformatf("drain%0d", i), 32'hA0 + 32'(i), 1'b1);
        end
        check_eq("drain.status", 64'(bus.status), 64'b11000);
        check_cnt("drain", 0, 0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("rst2.overflow", 64'(bus.overflow), 64'd0);

        // ---------------- wrap: 3 in/out, then 5 in/out across 4 -> 0
        for (int i = 0; i < 3; i++) push_w(32'(i));
        for (int i = 0; i < 3; i++) pop_chk($sformatf("wrapA%0d", i), 32'(i), 1'b1);
        for (int i = 3; i < 8; i++) push_w(32'(i));
        check_eq("wrap.full", 64'(bus.wr_ready), 64'd0);
        check_cnt("wrap.full", 5, 5);
        for (int i = 3; i < 8; i++) pop_chk($sformatf("wrapB%0d", i), 32'(i), 1'b1);
        check_eq("wrap.empty", 64'(bus.rd_valid), 64'd0);

        // ---------------- fall-through from empty
        push_w(32'h55);
        check_eq("fwft.valid", 64'(bus.rd_valid), 64'd1);
        check_eq("fwft.data",  64'(bus.rd_data),  64'h55);
        pop_chk("fwft.pop", 32'h55, 1'b1);
        check_eq("fwft.status", 64'(bus.status), 64'b11000);

        // ---------------- simultaneous push and pop
        push_w(32'h60);
        bus.rd_ready = 1'b1;
        push_w(32'h61);
        bus.rd_ready = 1'b0;
        check_cnt("pp", 2, 1);
        check_eq("pp.data", 64'(bus.rd_data), 64'h61);
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        check_cnt("pp.commit", 1, 1);
        pop_chk("pp.pop", 32'h61, 1'b1);
        check_cnt("pp.end", 0, 0);

        // ---------------- replay: push 4, pop 3, rewind
        for (int i = 0; i < 4; i++) push_w(32'hB0 + 32'(i));
        for (int i = 0; i < 3; i++) pop_chk($sformatf("rp%0d", i), 32'hB0 + 32'(i), 1'b0);
        check_cnt("rp.pre", 4, 1);
        check_eq("rp.pre.data", 64'(bus.rd_data), 64'hB3);
        bus.rewind = 1'b1;
        tick();
        bus.rewind = 1'b0;
        check_eq("rp.rew.data", 64'(bus.rd_data), 64'hB0);
        check_cnt("rp.rew", 4, 4);
        pop_chk("rp.again0", 32'hB0, 1'b0);
        pop_chk("rp.again1", 32'hB1, 1'b0);
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        check_cnt("rp.commit", 2, 2);
        check_eq("rp.commit.data", 64'(bus.rd_data), 64'hB2);

        // ---------------- commit+rewind together: commit wins
        push_w(32'hC0);
        push_w(32'hC1);
        pop_chk("cr0", 32'hB2, 1'b0);
        pop_chk("cr1", 32'hB3, 1'b0);
        bus.commit = 1'b1;
        bus.rewind = 1'b1;
        tick();
        idle();
        check_cnt("cr", 2, 2);
        check_eq("cr.data", 64'(bus.rd_data), 64'hC0);

        // pop in the rewind cycle is dropped
        pop_chk("pr0", 32'hC0, 1'b0);
        check_cnt("pr.pre", 2, 1);
        bus.rd_ready = 1'b1;
        bus.rewind   = 1'b1;
        tick();
        idle();
        check_cnt("pr", 2, 2);
        check_eq("pr.data", 64'(bus.rd_data), 64'hC0);

        // rewind with a push in the same cycle
        pop_chk("rw0", 32'hC0, 1'b0);
        bus.rewind = 1'b1;
        push_w(32'hD0);
        idle();
        check_cnt("rwp", 3, 3);
        check_eq("rwp.data", 64'(bus.rd_data), 64'hC0);

        // ---------------- reset mid-replay
        pop_chk("mr0", 32'hC0, 1'b0);
        pop_chk("mr1", 32'hC1, 1'b0);
        pop_chk("mr2", 32'hD0, 1'b0);
        check_cnt("mr.pre", 3, 0);
        reset        = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'hFF;
        bus.rd_ready = 1'b1;
        bus.rewind   = 1'b1;
        tick();
        idle();
        reset = 1'b0;
        check_eq("mr.status",   64'(bus.status),   64'b11000);
        check_eq("mr.wr_ready", 64'(bus.wr_ready), 64'd1);
        check_eq("mr.rd_valid", 64'(bus.rd_valid), 64'd0);
        check_cnt("mr", 0, 0);
        push_w(32'hE0);
        check_eq("mr.after", 64'(bus.rd_data), 64'hE0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
